// File: rtl/pht_update_queue.sv
// rtl/pht_update_queue.sv - commit-side PHT update FIFO feeding the branch-repair bus
//
// Buffers up to two resolved conditional branches per cycle from commit and
// drains one PHT update per cycle when the repair bus is granted.
// Optional feature: define PHT_UPD_FILTER_EN to drop updates that cannot
// change a saturated counter (correct prediction into an already-saturated
// counter in the same direction).
//
// Ports:
//   clk                  clock, all state on rising edge
//   rst                  asynchronous active-low reset
//   CMT_valid_i[1:0]     per-slot resolved branch valid, slot 0 older
//   CMT_vAddr_i[63:0]    {slot1, slot0} branch VAddr
//   CMT_checkPoint_i     {slot1, slot0} 2-bit PHT counter from predict time
//   CMT_predTake_i       predicted direction per slot
//   CMT_realTake_i       resolved direction per slot
//   CMT_ready_o          at least two free entries
//   FU_repairGrant_i     repair bus granted this cycle
//   FU_repairAction_w_o  NEED_REPAIR bit + PHT_ACTION field of the head
//   FU_allCheckPoint_w_o PHT_CHECK_COUNT field = head checkpoint
//   FU_erroVAddr_w_o     head branch VAddr
//   FU_correctTake_w_o   head resolved direction

`ifndef REPAIR_ACTION
`define REPAIR_ACTION 4
`endif
`ifndef NEED_REPAIR
`define NEED_REPAIR 0
`endif
`ifndef PHT_ACTION
`define PHT_ACTION 2:1
`endif
`ifndef PHT_REPAIRE
`define PHT_REPAIRE 2'b01
`endif
`ifndef PHT_DIRECT
`define PHT_DIRECT 2'b10
`endif
`ifndef ALL_CHECKPOINT
`define ALL_CHECKPOINT 8
`endif
`ifndef PHT_CHECK_COUNT
`define PHT_CHECK_COUNT 1:0
`endif

module pht_update_queue #(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  CMT_valid_i,
  input  logic [63:0]                 CMT_vAddr_i,
  input  logic [3:0]                  CMT_checkPoint_i,
  input  logic [1:0]                  CMT_predTake_i,
  input  logic [1:0]                  CMT_realTake_i,
  output logic                        CMT_ready_o,
  input  logic                        FU_repairGrant_i,
  output logic [`REPAIR_ACTION-1:0]   FU_repairAction_w_o,
  output logic [`ALL_CHECKPOINT-1:0]  FU_allCheckPoint_w_o,
  output logic [31:0]                 FU_erroVAddr_w_o,
  output logic                        FU_correctTake_w_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [31:0]   vaddr_q [DEPTH];
  logic [31:0]   vaddr_d [DEPTH];
  logic [1:0]    ckpt_q  [DEPTH];
  logic [1:0]    ckpt_d  [DEPTH];
  logic          take_q  [DEPTH];
  logic          take_d  [DEPTH];
  logic          mis_q   [DEPTH];
  logic          mis_d   [DEPTH];

  logic          ready;
  logic          nonempty;
  logic          pop;
  logic [1:0]    mis;
  logic [1:0]    keep;
  logic [AW-1:0] idx1;

  always_comb begin
    // Ready looks only at registered occupancy, never at this cycle's grant.
    ready    = (count_q <= CW'(DEPTH - 2));
    nonempty = (count_q != '0);
    pop      = nonempty & FU_repairGrant_i;

    for (int s = 0; s < 2; s++) begin
      mis[s] = CMT_predTake_i[s] ^ CMT_realTake_i[s];
`ifdef PHT_UPD_FILTER_EN
      // A correct prediction into a counter already saturated in that
      // direction leaves the counter unchanged, so it needs no update.
      keep[s] = CMT_valid_i[s] & ready &
                ~(~mis[s] &
                  (((CMT_checkPoint_i[2*s +: 2] == 2'b11) &  CMT_realTake_i[s]) |
                   ((CMT_checkPoint_i[2*s +: 2] == 2'b00) & ~CMT_realTake_i[s])));
`else
      keep[s] = CMT_valid_i[s] & ready;
`endif
    end

    // Slot 1 lands right behind slot 0 only when slot 0 actually took a slot.
    idx1 = wptr_q + AW'(keep[0]);

    for (int i = 0; i < DEPTH; i++) begin
      vaddr_d[i] = vaddr_q[i];
      ckpt_d[i]  = ckpt_q[i];
      take_d[i]  = take_q[i];
      mis_d[i]   = mis_q[i];
    end
    if (keep[0]) begin
      vaddr_d[wptr_q] = CMT_vAddr_i[31:0];
      ckpt_d[wptr_q]  = CMT_checkPoint_i[1:0];
      take_d[wptr_q]  = CMT_realTake_i[0];
      mis_d[wptr_q]   = mis[0];
    end
    if (keep[1]) begin
      vaddr_d[idx1] = CMT_vAddr_i[63:32];
      ckpt_d[idx1]  = CMT_checkPoint_i[3:2];
      take_d[idx1]  = CMT_realTake_i[1];
      mis_d[idx1]   = mis[1];
    end

    wptr_d  = wptr_q + AW'(keep[0]) + AW'(keep[1]);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + CW'(keep[0]) + CW'(keep[1]) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        vaddr_q[i] <= '0;
        ckpt_q[i]  <= '0;
        take_q[i]  <= 1'b0;
        mis_q[i]   <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        vaddr_q[i] <= vaddr_d[i];
        ckpt_q[i]  <= ckpt_d[i];
        take_q[i]  <= take_d[i];
        mis_q[i]   <= mis_d[i];
      end
    end
  end

  always_comb begin
    CMT_ready_o          = ready;
    FU_repairAction_w_o  = '0;
    FU_allCheckPoint_w_o = '0;
    FU_erroVAddr_w_o     = '0;
    FU_correctTake_w_o   = 1'b0;
    if (nonempty) begin
      FU_repairAction_w_o[`NEED_REPAIR]      = pop;
      FU_repairAction_w_o[`PHT_ACTION]       = mis_q[rptr_q] ? `PHT_REPAIRE : `PHT_DIRECT;
      FU_allCheckPoint_w_o[`PHT_CHECK_COUNT] = ckpt_q[rptr_q];
      FU_erroVAddr_w_o                       = vaddr_q[rptr_q];
      FU_correctTake_w_o                     = take_q[rptr_q];
    end
  end

endmodule
